// File: rtl/time_keeper_pkg.sv
// Shared constants, mode encoding and wrap-around field stepping for the time keeper.
package time_pkg;
    localparam int TW = 6;

    localparam logic [TW-1:0] HR_MAX  = 6'd23;
    localparam logic [TW-1:0] MIN_MAX = 6'd59;
    localparam logic [TW-1:0] SEC_MAX = 6'd59;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_HR   = 3'd1,
        SET_MIN  = 3'd2,
        SET_AHR  = 3'd3,
        SET_AMIN = 3'd4
    } mode_t;

    // One button step on a field that wraps between 0 and max in both directions.
    function automatic logic [TW-1:0] step_field(input logic [TW-1:0] v,
                                                 input logic [TW-1:0] max,
                                                 input logic          up,
                                                 input logic          down);
        logic [TW-1:0] r;
        r = v;
        if (up)
            r = (v == max) ? '0 : v + 1'b1;
        else if (down)
            r = (v == '0) ? max : v - 1'b1;
        return r;
    endfunction
endpackage

// File: rtl/time_keeper_if.sv
// Button inputs and time/alarm outputs of the time keeper; slave = keeper, master = user side.
interface time_keeper_if;
    logic [3:0]              btn;
    logic [time_pkg::TW-1:0] c_hour;
    logic [time_pkg::TW-1:0] c_min;
    logic [time_pkg::TW-1:0] c_sec;
    logic [time_pkg::TW-1:0] a_hr;
    logic [time_pkg::TW-1:0] a_min;
    logic [2:0]              mode;
    logic                    tick_1hz;
    logic                    chime;

    modport master (output btn,
                    input  c_hour, c_min, c_sec, a_hr, a_min, mode, tick_1hz, chime);
    modport slave  (input  btn,
                    output c_hour, c_min, c_sec, a_hr, a_min, mode, tick_1hz, chime);
endinterface

// File: rtl/time_keeper_btn_pulse.sv
// Two-flop synchroniser plus rising-edge detect; one registered pulse per button press.
module btn_pulse (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);
    logic [2:0] sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[1:0], raw};
            pulse <= sync[1] & ~sync[2];
        end
    end
endmodule

// File: rtl/time_keeper.sv
// 24 h clock with alarm-time registers, 1 Hz prescaler and button-driven set-mode FSM.
// Optional hourly chime pulse is built only when CHIME_EN is defined.
module time_keeper
    import time_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input logic           clk,
    input logic           rst,
    time_keeper_if.slave  bus
);
    localparam int            PW      = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

    logic [3:0]    pulse;
    mode_t         state_q, state_d;
    logic [PW-1:0] presc;
    logic [TW-1:0] c_hour, c_min, c_sec, a_hr, a_min;
    logic          inc, dec, leave_min, clk_hold, tick;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_pulse u_btn (.clk(clk), .rst(rst), .raw(bus.btn[i]), .pulse(pulse[i]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // Exit outranks advance outranks increment outranks decrement; one action per cycle.
    always_comb begin
        state_d   = state_q;
        inc       = 1'b0;
        dec       = 1'b0;
        leave_min = 1'b0;
        if (pulse[3]) begin
            state_d = RUN;
        end else if (pulse[0]) begin
            case (state_q)
                RUN:      state_d = SET_HR;
                SET_HR:   state_d = SET_MIN;
                SET_MIN:  state_d = SET_AHR;
                SET_AHR:  state_d = SET_AMIN;
                default:  state_d = RUN;
            endcase
        end else if (pulse[1]) begin
            inc = (state_q != RUN);
        end else if (pulse[2]) begin
            dec = (state_q != RUN);
        end
        leave_min = (state_q == SET_MIN) && (pulse[3] || pulse[0]);
    end

    assign clk_hold = (state_q == SET_HR) || (state_q == SET_MIN);
    assign tick     = !clk_hold && (presc == PRE_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc  <= '0;
            c_sec  <= '0;
            c_min  <= '0;
            c_hour <= '0;
            a_hr   <= '0;
            a_min  <= '0;
        end else begin
            presc <= (clk_hold || tick) ? '0 : presc + 1'b1;

            if (leave_min)
                c_sec <= '0;
            else if (tick)
                c_sec <= step_field(c_sec, SEC_MAX, 1'b1, 1'b0);

            // Seconds/minutes carries ripple within the same edge as the tick.
            if (tick && c_sec == SEC_MAX)
                c_min <= step_field(c_min, MIN_MAX, 1'b1, 1'b0);
            else if (state_q == SET_MIN)
                c_min <= step_field(c_min, MIN_MAX, inc, dec);

            if (tick && c_sec == SEC_MAX && c_min == MIN_MAX)
                c_hour <= step_field(c_hour, HR_MAX, 1'b1, 1'b0);
            else if (state_q == SET_HR)
                c_hour <= step_field(c_hour, HR_MAX, inc, dec);

            if (state_q == SET_AHR)
                a_hr <= step_field(a_hr, HR_MAX, inc, dec);
            if (state_q == SET_AMIN)
                a_min <= step_field(a_min, MIN_MAX, inc, dec);
        end
    end

`ifdef CHIME_EN
    logic chime_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) chime_q <= 1'b0;
        else     chime_q <= tick && (c_sec == SEC_MAX) && (c_min == MIN_MAX);
    end

    assign bus.chime = chime_q;
`else
    assign bus.chime = 1'b0;
`endif

    assign bus.c_hour   = c_hour;
    assign bus.c_min    = c_min;
    assign bus.c_sec    = c_sec;
    assign bus.a_hr     = a_hr;
    assign bus.a_min    = a_min;
    assign bus.mode     = state_q;
    assign bus.tick_1hz = tick;
endmodule

// File: tb/tb_time_keeper.sv
// Scoreboard bench for time_keeper: a seconds-of-day reference model predicts every cycle.
module tb_time_keeper;
    localparam int CLK_HZ = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    time_keeper_if bus ();

    time_keeper #(.CLK_HZ(CLK_HZ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hr, mn, sc, ahr, amn, md;
        bit tick, chime;
    } snap_t;

    snap_t q[$];
    int    checks = 0;
    int    errors = 0;

    // Reference state: time of day in seconds, alarm in minutes of day.
    int       t_day, a_day, md, presc;
    bit       chime_m;
    bit [3:0] hist [0:4];

    function automatic snap_t snap();
        snap_t s;
        s.hr    = t_day / 3600;
        s.mn    = (t_day / 60) % 60;
        s.sc    = t_day % 60;
        s.ahr   = a_day / 60;
        s.amn   = a_day % 60;
        s.md    = md;
        s.tick  = !(md == 1 || md == 2) && presc == CLK_HZ - 1;
        s.chime = chime_m;
        return s;
    endfunction

    initial begin : model
        bit [3:0] p;
        bit       hold, tck, leave;
        int       nmd, delta, h, m;
        bus.btn = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                t_day = 0; a_day = 0; md = 0; presc = 0; chime_m = 0;
                for (int i = 0; i < 5; i++) hist[i] = '0;
                q.push_back(snap());
            end else begin
                for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = bus.btn;
                p     = hist[3] & ~hist[4];
                hold  = (md == 1 || md == 2);
                tck   = !hold && presc == CLK_HZ - 1;
                nmd   = md;
                delta = 0;
                if (p[3])                  nmd = 0;
                else if (p[0])             nmd = (md + 1) % 5;
                else if (p[1] && md != 0)  delta = 1;
                else if (p[2] && md != 0)  delta = -1;
                leave = (md == 2) && (p[3] || p[0]);
`ifdef CHIME_EN
                chime_m = tck && (t_day % 3600 == 3599);
`else
                chime_m = 0;
`endif
                if (tck) t_day = (t_day + 1) % 86400;
                presc = (hold || tck) ? 0 : presc + 1;
                case (md)
                    1: begin
                        h     = (t_day / 3600 + delta + 24) % 24;
                        t_day = h * 3600 + t_day % 3600;
                    end
                    2: begin
                        m     = ((t_day / 60) % 60 + delta + 60) % 60;
                        t_day = (t_day / 3600) * 3600 + m * 60 + t_day % 60;
                    end
                    3: a_day = ((a_day / 60 + delta + 24) % 24) * 60 + a_day % 60;
                    4: a_day = (a_day / 60) * 60 + (a_day % 60 + delta + 60) % 60;
                    default: ;
                endcase
                if (leave) t_day = t_day - t_day % 60;
                md = nmd;
                q.push_back(snap());
            end
        end
    end

    initial begin : monitor
        snap_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (bus.c_hour !== 6'(e.hr) || bus.c_min !== 6'(e.mn) || bus.c_sec !== 6'(e.sc) ||
                    bus.a_hr !== 6'(e.ahr) || bus.a_min !== 6'(e.amn) || bus.mode !== 3'(e.md) ||
                    bus.tick_1hz !== e.tick || bus.chime !== e.chime) begin
                    errors++;
                    if (errors <= 20)
                        $display("FAIL state @%0t: got %0d:%0d:%0d al %0d:%0d mode %0d tick %b chime %b, want %0d:%0d:%0d al %0d:%0d mode %0d tick %b chime %b",
                                 $time, bus.c_hour, bus.c_min, bus.c_sec, bus.a_hr, bus.a_min,
                                 bus.mode, bus.tick_1hz, bus.chime, e.hr, e.mn, e.sc, e.ahr,
                                 e.amn, e.md, e.tick, e.chime);
                end
            end
        end
    end

    task automatic check_val(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic press(input logic [3:0] mask, input int hold_cyc, input int gap_cyc);
        @(negedge clk);
        bus.btn = mask;
        repeat (hold_cyc) @(negedge clk);
        bus.btn = '0;
        repeat (gap_cyc) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        bus.btn = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin : stim
        int r;
        logic [3:0] mask;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Free run: 240 clocks at 4 clocks per second is one minute.
        repeat (240) @(posedge clk);
        @(negedge clk);
        check_val("free_run_hour", int'(bus.c_hour), 0);
        check_val("free_run_min", int'(bus.c_min), 1);
        check_val("free_run_sec", int'(bus.c_sec), 0);

        // Preload 23:59:00 then run through midnight.
        press(4'b0001, 2, 6);
        press(4'b0100, 2, 6);
        press(4'b0001, 2, 6);
        press(4'b0100, 2, 6);
        press(4'b0100, 2, 6);
        press(4'b1000, 2, 6);
        check_val("preload_mode", int'(bus.mode), 0);
        check_val("preload_hour", int'(bus.c_hour), 23);
        check_val("preload_min", int'(bus.c_min), 59);
        repeat (250) @(negedge clk);
        check_val("midnight_hour", int'(bus.c_hour), 0);
        check_val("midnight_min", int'(bus.c_min), 0);

        // Hour wrap in both directions while the clock is frozen.
        press(4'b0001, 2, 6);
        press(4'b0100, 3, 12);
        check_val("set_hr_dec_wrap", int'(bus.c_hour), 23);
        press(4'b0010, 3, 12);
        check_val("set_hr_inc_wrap", int'(bus.c_hour), 0);

        // Leave SET_MIN: seconds cleared, clock resumes in alarm setting.
        press(4'b0001, 2, 6);
        press(4'b0001, 2, 20);
        check_val("alarm_mode", int'(bus.mode), 3);
        press(4'b0011, 2, 8);
        check_val("coincident_mode", int'(bus.mode), 4);
        check_val("coincident_ahr", int'(bus.a_hr), 0);

        // Held increment gives one step; reset mid-hold clears everything.
        @(negedge clk);
        bus.btn = 4'b0010;
        repeat (30) @(negedge clk);
        check_val("hold_amin", int'(bus.a_min), 1);
        pulse_reset();
        @(negedge clk);
        check_val("reset_mode", int'(bus.mode), 0);
        check_val("reset_amin", int'(bus.a_min), 0);

        // Randomised presses, including overlapping buttons and occasional resets.
        for (int n = 0; n < 250; n++) begin
            r    = int'($urandom_range(0, 9));
            mask = (r < 8) ? 4'(1 << (r % 4)) : 4'($urandom_range(1, 15));
            press(mask, int'($urandom_range(1, 5)), int'($urandom_range(1, 8)));
            if ($urandom_range(0, 3) == 0) repeat (int'($urandom_range(4, 40))) @(negedge clk);
            if ($urandom_range(0, 49) == 0) pulse_reset();
        end
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
